// File: rtl/ub_read_sequencer.sv
// Burst read sequencer for unified buffer port 0.
// Issues row reads and tags buffer output rows with valid/last.
module ub_read_sequencer #(
    parameter int TILE_WIDTH = 4096,
    parameter int LEN_WIDTH  = 16,
    localparam int ADDR_WIDTH = $clog2(TILE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  master_en,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic                  en0,
    output logic                  row_valid,
    output logic                  row_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [2:0]            vld;
    logic [2:0]            lst;
    logic                  issue;
    logic                  accept;
    logic                  final_issue;
    logic [ADDR_WIDTH-1:0] addr_next;

    assign issue       = (state == ISSUE) & enable & ~master_en;
    assign accept      = cmd_valid & cmd_ready;
    assign final_issue = issue & (remaining == LEN_WIDTH'(1));
    assign addr_next   = (addr == ADDR_WIDTH'(TILE_WIDTH - 1)) ?
                         '0 : addr + ADDR_WIDTH'(1);

    assign cmd_ready = (state == IDLE) & ~done;
    assign busy      = (state != IDLE);
    assign en0       = issue;
    assign addr0     = addr;
    assign row_valid = vld[2];
    assign row_last  = vld[2] & lst[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            vld       <= '0;
            lst       <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            addr      <= cmd_addr;
                            remaining <= cmd_len;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addr      <= addr_next;
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (final_issue) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Final row leaves the read pipeline on this edge.
                    if (enable & vld[2] & lst[2]) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (enable) begin
                vld <= {vld[1:0], issue};
                lst <= {lst[1:0], final_issue};
            end
        end
    end

endmodule
